// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: walks T0..T5 per instruction and Moore-decodes
// the datapath control strobes from the current step and the instruction register.
`timescale 1ns/1ps

module control_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      IR,
  input  logic             Mem_Ready,
  input  logic             Stop,
  output logic             PC_Out,
  output logic             ZLO_Out,
  output logic             MDR_Out,
  output logic             MAR_In,
  output logic             PC_In,
  output logic             MDR_In,
  output logic             IR_In,
  output logic             Y_In,
  output logic             Z_In,
  output logic             IncPC,
  output logic             Read,
  output logic [3:0]       CONTROL,
  output logic [15:0]      R_Out,
  output logic [15:0]      R_In,
  output logic             Run,
  output logic             Illegal,
  output logic [CNT_W-1:0] Instr_Count
);

  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned NUM_GPR = 16;
  localparam int unsigned CTRL_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [CTRL_W-1:0] ALU_IDLE = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0100;

  typedef enum logic [2:0] {
    ST_RST,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_HALT
  } state_e;

  state_e           state_q, state_d;
  logic             stop_pending_q, stop_pending_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [OP_W-1:0]   opcode;
  logic [REG_W-1:0]  ra, rb, rc;
  logic [14:0]       unused_ir_low;
  logic              op_is_alu, op_is_nop, op_is_halt;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              stop_seen_c;
  state_e            after_retire_c;

  assign opcode        = IR[31:27];
  assign ra            = IR[26:23];
  assign rb            = IR[22:19];
  assign rc            = IR[18:15];
  assign unused_ir_low = IR[14:0];

  function automatic logic [NUM_GPR-1:0] gpr_sel(input logic [REG_W-1:0] idx);
    return NUM_GPR'(1) << idx;
  endfunction

  // Opcode classification and ALU function select.
  always_comb begin
    op_is_alu  = 1'b0;
    op_is_nop  = 1'b0;
    op_is_halt = 1'b0;
    alu_ctrl   = ALU_IDLE;
    case (opcode)
      OP_ADD:  begin op_is_alu = 1'b1; alu_ctrl = ALU_ADD; end
      OP_SUB:  begin op_is_alu = 1'b1; alu_ctrl = ALU_SUB; end
      OP_AND:  begin op_is_alu = 1'b1; alu_ctrl = ALU_AND; end
      OP_OR:   begin op_is_alu = 1'b1; alu_ctrl = ALU_OR;  end
      OP_NOP:  op_is_nop  = 1'b1;
      OP_HALT: op_is_halt = 1'b1;
      default: ;
    endcase
  end

  // A stop raised in the retiring cycle itself still halts after this instruction.
  assign stop_seen_c    = stop_pending_q | Stop;
  assign after_retire_c = stop_seen_c ? ST_HALT : ST_T0;

  // Next-state and Moore strobe decode.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    stop_pending_d = stop_pending_q | Stop;
    PC_Out         = 1'b0;
    ZLO_Out        = 1'b0;
    MDR_Out        = 1'b0;
    MAR_In         = 1'b0;
    PC_In          = 1'b0;
    MDR_In         = 1'b0;
    IR_In          = 1'b0;
    Y_In           = 1'b0;
    Z_In           = 1'b0;
    IncPC          = 1'b0;
    Read           = 1'b0;
    CONTROL        = ALU_IDLE;
    R_Out          = '0;
    R_In           = '0;
    Run            = 1'b0;
    Illegal        = 1'b0;

    case (state_q)
      ST_RST: begin
        state_d = ST_T0;
      end
      ST_T0: begin
        Run     = 1'b1;
        PC_Out  = 1'b1;
        MAR_In  = 1'b1;
        IncPC   = 1'b1;
        Z_In    = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        // Strobes stay up while waiting; reloading PC from an unchanged Z is harmless.
        Run     = 1'b1;
        ZLO_Out = 1'b1;
        PC_In   = 1'b1;
        Read    = 1'b1;
        MDR_In  = 1'b1;
        if (Mem_Ready) begin
          state_d = ST_T2;
        end
      end
      ST_T2: begin
        Run     = 1'b1;
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        Run = 1'b1;
        if (op_is_alu) begin
          R_Out   = gpr_sel(rb);
          Y_In    = 1'b1;
          state_d = ST_T4;
        end else if (op_is_nop) begin
          count_d = count_q + CNT_W'(1);
          state_d = after_retire_c;
        end else if (op_is_halt) begin
          count_d = count_q + CNT_W'(1);
          state_d = ST_HALT;
        end else begin
          Illegal = 1'b1;
          state_d = after_retire_c;
        end
      end
      ST_T4: begin
        Run     = 1'b1;
        R_Out   = gpr_sel(rc);
        CONTROL = alu_ctrl;
        Z_In    = 1'b1;
        state_d = ST_T5;
      end
      ST_T5: begin
        Run     = 1'b1;
        ZLO_Out = 1'b1;
        R_In    = gpr_sel(ra);
        count_d = count_q + CNT_W'(1);
        state_d = after_retire_c;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // State, retired count and stop request; Reset wins over everything.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= ST_RST;
      stop_pending_q <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      stop_pending_q <= stop_pending_d;
      count_q        <= count_d;
    end
  end

  assign Instr_Count = count_q;

  // Structural invariants of the strobe decode.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      assert ($onehot0(R_Out));
      assert ($onehot0(R_In));
      assert (Run || (R_Out == '0 && R_In == '0 && CONTROL == ALU_IDLE && !Illegal));
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction expectations are queued
// from a behavioural model and matched against observed instruction windows.
`timescale 1ns/1ps

module tb_control_sequencer;

  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] I_NOP  = 32'hD000_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;
  localparam logic [31:0] I_ILL  = 32'hF800_0000;
  localparam int          NO_STOP = 1_000_000;

  logic             Clock;
  logic             Reset;
  logic [31:0]      IR;
  logic             Mem_Ready;
  logic             Stop;
  logic             PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In;
  logic             Y_In, Z_In, IncPC, Read, Run, Illegal;
  logic [3:0]       CONTROL;
  logic [15:0]      R_Out, R_In;
  logic [CNT_W-1:0] Instr_Count;

  control_sequencer #(.CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Mem_Ready(Mem_Ready), .Stop(Stop),
    .PC_Out(PC_Out), .ZLO_Out(ZLO_Out), .MDR_Out(MDR_Out), .MAR_In(MAR_In),
    .PC_In(PC_In), .MDR_In(MDR_In), .IR_In(IR_In), .Y_In(Y_In), .Z_In(Z_In),
    .IncPC(IncPC), .Read(Read), .CONTROL(CONTROL), .R_Out(R_Out), .R_In(R_In),
    .Run(Run), .Illegal(Illegal), .Instr_Count(Instr_Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  wire [48:0] all_out = {PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In,
                         Y_In, Z_In, IncPC, Read, CONTROL, R_Out, R_In, Run, Illegal};
  wire [48:0] t0_exp  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0};

  typedef struct {
    int               cycles;
    logic [15:0]      y_mask;
    logic [15:0]      z_mask;
    logic [3:0]       ctrl;
    logic [15:0]      r_in;
    int               ill;
    logic [CNT_W-1:0] cnt;
  } rec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  rec_t        exp_q[$];
  logic [31:0] prog[$];
  int          stalls[$];
  int          stop_at  = NO_STOP;
  int          stop_off = 0;
  bit          mon_en   = 1'b0;
  bit          mon_busy = 1'b0;
  logic [CNT_W-1:0] final_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics of one instruction, straight from the opcode table.
  function automatic void classify(input logic [31:0] ir, output bit is_alu,
                                   output bit counts, output bit is_halt,
                                   output logic [3:0] ctrl);
    is_alu = 0; counts = 0; is_halt = 0; ctrl = 4'd0;
    case (ir[31:27])
      5'b00011: begin is_alu = 1; ctrl = 4'd1; end
      5'b00100: begin is_alu = 1; ctrl = 4'd2; end
      5'b01001: begin is_alu = 1; ctrl = 4'd3; end
      5'b01010: begin is_alu = 1; ctrl = 4'd4; end
      5'b11010: counts = 1;
      5'b11011: begin counts = 1; is_halt = 1; end
      default: ;
    endcase
  endfunction

  function automatic bit is_legal(input logic [4:0] op);
    return op inside {5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b11010, 5'b11011};
  endfunction

  task automatic build_model();
    logic [CNT_W-1:0] cnt;
    bit alu, counts, halt;
    logic [3:0] ctrl;
    cnt = '0;
    exp_q.delete();
    for (int i = 0; i < prog.size(); i++) begin
      rec_t r;
      classify(prog[i], alu, counts, halt, ctrl);
      r.cycles = (alu ? 6 : 4) + stalls[i];
      r.y_mask = alu ? (16'd1 << prog[i][22:19]) : 16'd0;
      r.z_mask = alu ? (16'd1 << prog[i][18:15]) : 16'd0;
      r.r_in   = alu ? (16'd1 << prog[i][26:23]) : 16'd0;
      r.ctrl   = ctrl;
      r.ill    = (alu || counts) ? 0 : 1;
      if (alu || counts) cnt = cnt + 1'b1;
      r.cnt    = cnt;
      exp_q.push_back(r);
      if (halt || i == stop_at) break;
    end
    final_cnt = cnt;
  endtask

  // Datapath stand-in: loads IR on IR_In, answers memory reads, pulses Stop.
  initial begin
    int starts, cyc, ld_idx, stall_left;
    bit ir_load;
    starts = 0; cyc = 0; ld_idx = 0; stall_left = 0;
    Mem_Ready = 1'b1; Stop = 1'b0; IR = '0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        starts = 0; cyc = 0; ld_idx = 0; stall_left = 0; IR = '0;
      end
      if (PC_Out) begin
        starts++;
        cyc = 0;
        stall_left = (starts - 1 < stalls.size()) ? stalls[starts-1] : 0;
      end
      if (Read) begin
        Mem_Ready = (stall_left == 0);
        if (stall_left != 0) stall_left--;
      end else begin
        Mem_Ready = 1'($urandom);
      end
      Stop = !Reset && (starts == stop_at + 1) && (cyc == stop_off);
      cyc++;
      ir_load = IR_In && !Reset;
      @(posedge Clock);
      #1;
      if (ir_load) begin
        IR = (ld_idx < prog.size()) ? prog[ld_idx] : I_NOP;
        ld_idx++;
      end
    end
  end

  // Monitor: one record per T0-delimited instruction window.
  initial begin
    rec_t obs, e;
    obs = '{default: 0};
    forever begin
      @(negedge Clock);
      if (!mon_en) begin
        mon_busy = 1'b0;
      end else begin
        if (mon_busy && (!Run || PC_Out)) begin
          mon_busy = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_instr: got %0d cycles, expected no instruction", obs.cycles);
          end else begin
            e = exp_q.pop_front();
            check("cycles",  64'(obs.cycles), 64'(e.cycles));
            check("y_rout",  64'(obs.y_mask), 64'(e.y_mask));
            check("z_rout",  64'(obs.z_mask), 64'(e.z_mask));
            check("control", 64'(obs.ctrl),   64'(e.ctrl));
            check("r_in",    64'(obs.r_in),   64'(e.r_in));
            check("illegal", 64'(obs.ill),    64'(e.ill));
            check("count",   64'(Instr_Count), 64'(e.cnt));
          end
        end
        if (Run && PC_Out) begin
          mon_busy = 1'b1;
          obs = '{default: 0};
          check("t0_strobes", 64'(all_out), 64'(t0_exp));
        end else if (Run && !mon_busy) begin
          check("stray_run", 64'(Run), 64'(0));
        end
        if (mon_busy) begin
          obs.cycles++;
          if (Y_In) obs.y_mask = obs.y_mask | R_Out;
          else      obs.z_mask = obs.z_mask | (PC_Out ? 16'd0 : R_Out);
          obs.ctrl = obs.ctrl | CONTROL;
          obs.r_in = obs.r_in | R_In;
          if (Illegal) obs.ill++;
        end
      end
    end
  end

  task automatic new_prog();
    prog.delete();
    stalls.delete();
  endtask

  task automatic add_instr(input logic [31:0] ir, input int stall);
    prog.push_back(ir);
    stalls.push_back(stall);
  endtask

  task automatic apply_reset(input int stop_i, input int stop_o);
    mon_en = 1'b0;
    @(posedge Clock); #1 Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    check("reset_outputs", 64'(all_out), 64'(0));
    check("reset_count", 64'(Instr_Count), 64'(0));
    stop_at  = stop_i;
    stop_off = stop_o;
    @(posedge Clock); #1 Reset = 1'b0;
  endtask

  task automatic run_prog(input int stop_i, input int stop_o);
    int budget;
    apply_reset(stop_i, stop_o);
    build_model();
    mon_en = 1'b1;
    @(negedge Clock);
    check("rst_cycle_outputs", 64'(all_out), 64'(0));
    @(negedge Clock);
    check("first_t0", 64'(all_out), 64'(t0_exp));
    budget = 0;
    while ((exp_q.size() != 0 || mon_busy) && budget < 3000) begin
      @(negedge Clock);
      budget++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
    repeat (3) begin
      @(negedge Clock);
      check("halted_outputs", 64'(all_out), 64'(0));
    end
    check("final_count", 64'(Instr_Count), 64'(final_cnt));
  endtask

  task automatic reset_mid_test();
    int  budget;
    bit  rin_seen;
    new_prog();
    add_instr(32'h4A92_0000, 0);
    add_instr(I_HALT, 0);
    apply_reset(NO_STOP, 0);
    budget   = 0;
    rin_seen = 1'b0;
    do begin
      @(negedge Clock);
      rin_seen = rin_seen | (R_In != 16'd0);
      budget++;
    end while (!(Run && Z_In && !PC_Out) && budget < 50);
    check("t4_control", 64'(CONTROL), 64'(4'b0011));
    check("t4_rout", 64'(R_Out), 64'(16'h0010));
    Reset = 1'b1;
    @(negedge Clock);
    check("midreset_zin",  64'(Z_In), 64'(0));
    check("midreset_rout", 64'(R_Out), 64'(0));
    check("midreset_rin",  64'(R_In), 64'(0));
    check("midreset_run",  64'(Run), 64'(0));
    check("midreset_cnt",  64'(Instr_Count), 64'(0));
    check("midreset_no_rin_before", 64'(rin_seen), 64'(0));
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock);
    check("midreset_rst_run", 64'(Run), 64'(0));
    @(negedge Clock);
    check("midreset_restart_t0", 64'(all_out), 64'(t0_exp));
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] op;
    k = $urandom_range(0, 10);
    case (k)
      0, 4:    op = 5'b00011;
      1, 5:    op = 5'b00100;
      2, 6:    op = 5'b01001;
      3, 7:    op = 5'b01010;
      8:       op = 5'b11010;
      10:      op = 5'b11011;
      default: begin
        do op = 5'($urandom); while (is_legal(op));
      end
    endcase
    return {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    repeat (2) @(posedge Clock);

    new_prog(); add_instr(32'h4A92_0000, 0); add_instr(I_HALT, 0);
    run_prog(NO_STOP, 0);

    new_prog(); add_instr(32'h1A92_0000, 3); add_instr(I_HALT, 0);
    run_prog(NO_STOP, 0);

    new_prog(); add_instr(I_NOP, 0); add_instr(I_ILL, 0); add_instr(I_HALT, 0);
    run_prog(NO_STOP, 0);
    check("nop_ill_halt_count", 64'(Instr_Count), 64'(2));

    new_prog(); add_instr(32'h1A92_0000, 1); add_instr(32'h2311_8000, 0);
    add_instr(I_NOP, 0); add_instr(I_HALT, 0);
    run_prog(0, 1);
    check("stop_count", 64'(Instr_Count), 64'(1));

    new_prog(); add_instr(I_NOP, 0); add_instr(I_NOP, 0); add_instr(I_HALT, 0);
    run_prog(0, 3);

    reset_mid_test();

    for (int t = 0; t < 20; t++) begin
      int len;
      len = $urandom_range(2, 9);
      new_prog();
      for (int i = 0; i < len; i++)
        add_instr(rand_instr(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      add_instr(I_HALT, $urandom_range(0, 2));
      run_prog($urandom_range(0, 1) ? $urandom_range(0, len) : NO_STOP, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
